seven_segment_scan_controller: RTL and testbench

Time-multiplexed scan controller that shares one hex-to-seven-segment decoder across `NDIGITS` common-cathode digits. It holds the displayed value and presents one nibble at a time to the shared decoder. It registers the returned segment pattern and drives a one-hot digit enable, with an inter-digit ghosting guard and optional leading-zero blanking. New values are double-buffered and applied only at frame boundaries, so a display frame never shows a mix of old and new digits.

---
 rtl/seven_segment_scan_controller.sv | 117 +++++++++++
 tb/tb_seven_segment_scan_controller.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed scan controller for NDIGITS common-cathode digits sharing
// one external hex-to-seven-segment decoder. Displayed value is double-buffered
// and swapped only at frame boundaries; a blank guard cycle opens every digit
// slot to prevent ghosting, and leading zeros can optionally be suppressed.
module seven_segment_scan_controller #(
    parameter int NDIGITS = 4,
    parameter int DIV     = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic                   blank_lz,
    output logic [3:0]             hex_out,
    input  logic [6:0]             seg_in,
    output logic [6:0]             segments,
    output logic [NDIGITS-1:0]     digit_en,
    output logic                   frame_done
);

    localparam int TICK_W = $clog2(DIV);
    localparam int IDX_W  = $clog2(NDIGITS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NDIGITS - 1);

    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [4*NDIGITS-1:0] disp_q, disp_d;
    logic [4*NDIGITS-1:0] pend_q, pend_d;
    logic                 pend_v_q, pend_v_d;
    logic [6:0]           segments_q, segments_d;
    logic [NDIGITS-1:0]   digit_en_q, digit_en_d;
    logic                 frame_done_q, frame_done_d;

    logic tick_wrap;
    logic boundary;
    logic upper_nonzero;
    logic suppress;

    // The shared decoder always sees the nibble of the digit currently scanned.
    assign hex_out = disp_q[{idx_q, 2'b00} +: 4];

    // Leading-zero detection: digit idx is blank when it and every more
    // significant nibble are zero; digit 0 always shows so 0 reads as "0".
    always_comb begin
        upper_nonzero = 1'b0;
        for (int k = 0; k < NDIGITS; k++) begin
            if (k >= int'(idx_q) && disp_q[4*k +: 4] != 4'h0) begin
                upper_nonzero = 1'b1;
            end
        end
        suppress = blank_lz && (idx_q != '0) && !upper_nonzero;
    end

    // Next-state for scan counters, load buffering and registered outputs.
    always_comb begin
        tick_wrap = (tick_q == TICK_LAST);
        boundary  = tick_wrap && (idx_q == IDX_LAST);

        tick_d = tick_wrap ? '0 : tick_q + 1'b1;
        idx_d  = idx_q;
        if (tick_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        disp_d   = disp_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        if (load) begin
            pend_d   = value;
            pend_v_d = 1'b1;
        end
        // A load landing on the boundary itself bypasses the pending buffer.
        if (boundary) begin
            if (load) begin
                disp_d   = value;
                pend_v_d = 1'b0;
            end else if (pend_v_q) begin
                disp_d   = pend_q;
                pend_v_d = 1'b0;
            end
        end

        // tick 0 is the ghosting guard: everything dark while the decoder settles.
        segments_d   = (tick_q == '0 || suppress) ? 7'd0 : seg_in;
        digit_en_d   = (tick_q == '0) ? '0 : (NDIGITS'(1) << idx_q);
        frame_done_d = boundary;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q       <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_v_q     <= 1'b0;
            segments_q   <= '0;
            digit_en_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            segments_q   <= segments_d;
            digit_en_q   <= digit_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign segments   = segments_q;
    assign digit_en   = digit_en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Directed bench for seven_segment_scan_controller with NDIGITS=4, DIV=4 and a
// behavioural abc_defg decoder closing the hex_out -> seg_in loop.
module tb_seven_segment_scan_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic [3:0]  hex_out;
    logic [6:0]  seg_in;
    logic [6:0]  segments;
    logic [3:0]  digit_en;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [6:0] exp_seg [4];

    always #5 clk = ~clk;

    function automatic logic [6:0] dec7(input logic [3:0] h);
        case (h)
            4'h0: dec7 = 7'h7E; 4'h1: dec7 = 7'h30; 4'h2: dec7 = 7'h6D; 4'h3: dec7 = 7'h79;
            4'h4: dec7 = 7'h33; 4'h5: dec7 = 7'h5B; 4'h6: dec7 = 7'h5F; 4'h7: dec7 = 7'h70;
            4'h8: dec7 = 7'h7F; 4'h9: dec7 = 7'h7B; 4'hA: dec7 = 7'h77; 4'hB: dec7 = 7'h1F;
            4'hC: dec7 = 7'h4E; 4'hD: dec7 = 7'h3D; 4'hE: dec7 = 7'h4F; default: dec7 = 7'h47;
        endcase
    endfunction

    assign seg_in = dec7(hex_out);

    seven_segment_scan_controller #(.NDIGITS(4), .DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .value      (value),
        .blank_lz   (blank_lz),
        .hex_out    (hex_out),
        .seg_in     (seg_in),
        .segments   (segments),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic set_exp(input logic [6:0] s3, input logic [6:0] s2,
                           input logic [6:0] s1, input logic [6:0] s0);
        exp_seg[3] = s3; exp_seg[2] = s2; exp_seg[1] = s1; exp_seg[0] = s0;
    endtask

    // Outputs after edge n reflect state after edge n-1: tick=(n-1)%4, idx=((n-1)/4)%4.
    task automatic check_scan();
        int m, t, i;
        logic [3:0] e_en;
        logic [6:0] e_seg;
        m = cyc - 1;
        t = m % 4;
        i = (m / 4) % 4;
        e_en  = (t == 0) ? 4'b0000 : (4'b0001 << i);
        e_seg = (t == 0) ? 7'd0 : exp_seg[i];
        check_eq("digit_en", 32'(digit_en), 32'(e_en));
        check_eq("segments", 32'(segments), 32'(e_seg));
        check_eq("frame_done", 32'(frame_done), 32'((cyc % 16) == 0));
    endtask

    task automatic run_cycle(input logic ld, input logic [15:0] v);
        load  = ld;
        value = v;
        @(posedge clk);
        #1;
        cyc++;
        check_scan();
    endtask

    // One full frame; load_off selects the iteration (0..15) carrying a load, 15 = boundary.
    task automatic run_frame(input int load_off, input logic [15:0] lval);
        for (int j = 0; j < 16; j++) begin
            if (j == load_off) run_cycle(1'b1, lval);
            else               run_cycle(1'b0, 16'h0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        value    = 16'h0;
        blank_lz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_segments", 32'(segments), 32'h0);
        check_eq("rst_digit_en", 32'(digit_en), 32'h0);
        check_eq("rst_frame_done", 32'(frame_done), 32'h0);
        check_eq("rst_hex_out", 32'(hex_out), 32'h0);
        reset = 1'b0;
        cyc   = 0;

        // Frame A: never loaded, every digit shows 0.
        set_exp(7'h7E, 7'h7E, 7'h7E, 7'h7E);
        run_frame(-1, 16'h0);
        // Frame B: mid-frame load of 1A2F, old zeros persist.
        run_frame(5, 16'h1A2F);
        // Frame C: 1A2F displayed; blanking on has no effect; load 0030.
        blank_lz = 1'b1;
        set_exp(7'h30, 7'h77, 7'h6D, 7'h47);
        run_frame(3, 16'h0030);
        // Frame D: 0030 with leading-zero blanking; load 0000.
        set_exp(7'h00, 7'h00, 7'h79, 7'h7E);
        run_frame(7, 16'h0000);
        // Frame E: 0000 lights only digit 0; loads 1111 then 2222.
        set_exp(7'h00, 7'h00, 7'h00, 7'h7E);
        load = 1'b0;
        for (int j = 0; j < 16; j++) begin
            if (j == 2)      run_cycle(1'b1, 16'h1111);
            else if (j == 9) run_cycle(1'b1, 16'h2222);
            else             run_cycle(1'b0, 16'h0);
        end
        blank_lz = 1'b0;
        // Frame F: only 2222 appears; 3333 loaded on the boundary cycle.
        set_exp(7'h6D, 7'h6D, 7'h6D, 7'h6D);
        run_frame(15, 16'h3333);
        // Frame G: 3333 in the immediately following frame.
        set_exp(7'h79, 7'h79, 7'h79, 7'h79);
        run_frame(-1, 16'h0);
        // Frame H: load 4444 then reset while idx=2 with it pending.
        run_cycle(1'b1, 16'h4444);
        for (int j = 0; j < 8; j++) run_cycle(1'b0, 16'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst_segments", 32'(segments), 32'h0);
        check_eq("midrst_digit_en", 32'(digit_en), 32'h0);
        check_eq("midrst_frame_done", 32'(frame_done), 32'h0);
        check_eq("midrst_hex_out", 32'(hex_out), 32'h0);
        reset = 1'b0;
        cyc   = 0;
        // Scan restarts at digit 0 showing 0; 4444 must never surface.
        set_exp(7'h7E, 7'h7E, 7'h7E, 7'h7E);
        run_frame(-1, 16'h0);
        run_frame(-1, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
